// File: rtl/sort_stats_if.sv
`default_nettype none
// ============================================================================
//  Module   : sort_stats_if
//  Brief    : Bundle of the sorted-burst input and the statistics result
//             signals exchanged between the sort_stats block and its
//             neighbours. The master side feeds words in and reads results;
//             the slave side is the statistics block itself.
//  Revision : 1.0  initial release
// ============================================================================
interface sort_stats_if #(
    parameter int N = 8,
    parameter int K = 32
);
    localparam int CW = $clog2(K + 1);

    logic              data_in_en;
    logic [N-1:0]      data_in;
    logic              busy;
    logic              stats_valid;
    logic [CW-1:0]     word_cnt;
    logic [N-1:0]      min_out;
    logic [N-1:0]      max_out;
    logic [N-1:0]      median_out;
    logic [N+CW-1:0]   sum_out;
    logic [CW-1:0]     dup_cnt;
    logic              order_err;
    logic              overflow;

    // Upstream sorter / reporting logic side
    modport master (
        output data_in_en, data_in,
        input  busy, stats_valid, word_cnt, min_out, max_out, median_out,
               sum_out, dup_cnt, order_err, overflow
    );

    // Statistics block side
    modport slave (
        input  data_in_en, data_in,
        output busy, stats_valid, word_cnt, min_out, max_out, median_out,
               sum_out, dup_cnt, order_err, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sort_stats.sv
`default_nettype none
// ============================================================================
//  Module   : sort_stats
//  Brief    : Captures one contiguous sorted burst, checks ascending order and
//             reports min, max, lower median, sum and adjacent-duplicate
//             count with a one-cycle valid pulse. Results hold until the
//             next report.
//  Revision : 1.0  initial release
// ============================================================================
module sort_stats #(
    parameter int N = 8,
    parameter int K = 32
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sort_stats_if.slave bus
);
    localparam int CW = $clog2(K + 1);
    localparam int AW = $clog2(K);

    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_K   = CW'(K);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CAPT = 2'd1,
        S_MED  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;

    // Burst accumulators (private to the capture phase)
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      acc_min_q, acc_min_d;
    logic [N-1:0]      acc_max_q, acc_max_d;
    logic [N-1:0]      prev_q, prev_d;
    logic [N+CW-1:0]   acc_sum_q, acc_sum_d;
    logic [CW-1:0]     acc_dup_q, acc_dup_d;
    logic              acc_oerr_q, acc_oerr_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic [N-1:0]      med_q, med_d;

    // Published results
    logic              busy_q, busy_d;
    logic              stats_valid_q, stats_valid_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [N-1:0]      min_out_q, min_out_d;
    logic [N-1:0]      max_out_q, max_out_d;
    logic [N-1:0]      median_out_q, median_out_d;
    logic [N+CW-1:0]   sum_out_q, sum_out_d;
    logic [CW-1:0]     dup_cnt_q, dup_cnt_d;
    logic              order_err_q, order_err_d;
    logic              overflow_q, overflow_d;

    // Word buffer: contents are never reset, only written while capturing
    logic [N-1:0]      buf_q [K];
    logic              buf_we;
    logic [AW-1:0]     buf_idx;
    logic [AW-1:0]     med_idx;

    // Next-state / datapath decode for the capture-median-report sequence
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_min_d     = acc_min_q;
        acc_max_d     = acc_max_q;
        prev_d        = prev_q;
        acc_sum_d     = acc_sum_q;
        acc_dup_d     = acc_dup_q;
        acc_oerr_d    = acc_oerr_q;
        acc_ovf_d     = acc_ovf_q;
        med_d         = med_q;
        busy_d        = busy_q;
        stats_valid_d = 1'b0;
        word_cnt_d    = word_cnt_q;
        min_out_d     = min_out_q;
        max_out_d     = max_out_q;
        median_out_d  = median_out_q;
        sum_out_d     = sum_out_q;
        dup_cnt_d     = dup_cnt_q;
        order_err_d   = order_err_q;
        overflow_d    = overflow_q;
        buf_we        = 1'b0;
        buf_idx       = AW'(cnt_q);
        // Lower median position; cnt is at least 1 whenever this is used
        med_idx       = AW'((cnt_q - C_ONE) >> 1);

        case (state_q)
            S_IDLE: begin
                if (bus.data_in_en) begin
                    buf_we     = 1'b1;
                    buf_idx    = '0;
                    cnt_d      = C_ONE;
                    acc_min_d  = bus.data_in;
                    acc_max_d  = bus.data_in;
                    prev_d     = bus.data_in;
                    acc_sum_d  = {{CW{1'b0}}, bus.data_in};
                    acc_dup_d  = '0;
                    acc_oerr_d = 1'b0;
                    acc_ovf_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_CAPT;
                end
            end
            S_CAPT: begin
                if (!bus.data_in_en) begin
                    state_d = S_MED;
                end else if (cnt_q < C_K) begin
                    buf_we    = 1'b1;
                    cnt_d     = cnt_q + C_ONE;
                    acc_sum_d = acc_sum_q + {{CW{1'b0}}, bus.data_in};
                    prev_d    = bus.data_in;
                    if (bus.data_in < acc_min_q) acc_min_d = bus.data_in;
                    if (bus.data_in > acc_max_q) acc_max_d = bus.data_in;
                    if (bus.data_in < prev_q)    acc_oerr_d = 1'b1;
                    if (bus.data_in == prev_q)   acc_dup_d = acc_dup_q + C_ONE;
                end else begin
                    // Buffer full: the word is dropped, stats cover the first K
                    acc_ovf_d = 1'b1;
                end
            end
            S_MED: begin
                med_d   = buf_q[med_idx];
                state_d = S_DONE;
            end
            S_DONE: begin
                word_cnt_d    = cnt_q;
                min_out_d     = acc_min_q;
                max_out_d     = acc_max_q;
                median_out_d  = med_q;
                sum_out_d     = acc_sum_q;
                dup_cnt_d     = acc_dup_q;
                order_err_d   = acc_oerr_q;
                overflow_d    = acc_ovf_q;
                stats_valid_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control, accumulator and result registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_min_q     <= '0;
            acc_max_q     <= '0;
            prev_q        <= '0;
            acc_sum_q     <= '0;
            acc_dup_q     <= '0;
            acc_oerr_q    <= 1'b0;
            acc_ovf_q     <= 1'b0;
            med_q         <= '0;
            busy_q        <= 1'b0;
            stats_valid_q <= 1'b0;
            word_cnt_q    <= '0;
            min_out_q     <= '0;
            max_out_q     <= '0;
            median_out_q  <= '0;
            sum_out_q     <= '0;
            dup_cnt_q     <= '0;
            order_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_min_q     <= acc_min_d;
            acc_max_q     <= acc_max_d;
            prev_q        <= prev_d;
            acc_sum_q     <= acc_sum_d;
            acc_dup_q     <= acc_dup_d;
            acc_oerr_q    <= acc_oerr_d;
            acc_ovf_q     <= acc_ovf_d;
            med_q         <= med_d;
            busy_q        <= busy_d;
            stats_valid_q <= stats_valid_d;
            word_cnt_q    <= word_cnt_d;
            min_out_q     <= min_out_d;
            max_out_q     <= max_out_d;
            median_out_q  <= median_out_d;
            sum_out_q     <= sum_out_d;
            dup_cnt_q     <= dup_cnt_d;
            order_err_q   <= order_err_d;
            overflow_q    <= overflow_d;
        end
    end

    // Burst storage write port
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_idx] <= bus.data_in;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.stats_valid = stats_valid_q;
    assign bus.word_cnt    = word_cnt_q;
    assign bus.min_out     = min_out_q;
    assign bus.max_out     = max_out_q;
    assign bus.median_out  = median_out_q;
    assign bus.sum_out     = sum_out_q;
    assign bus.dup_cnt     = dup_cnt_q;
    assign bus.order_err   = order_err_q;
    assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire
